// File: rtl/cpu_sequencer.sv
// Instruction sequencer FSM: fetch/decode/execute control strobes for a small accumulator CPU.
// Optional macro SEQ_WAIT_STATE_EN enables mem_ready wait states in F_READ, M_READ and M_WRITE.
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] ir_opcode,
    input  logic       mem_ready,
    output logic       load_mar,
    output logic       load_mbr,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_acc,
    output logic       read_rom,
    output logic       read_ram,
    output logic       write_ram,
    output logic [1:0] alu_sel,
    output logic [1:0] mux_sel_u9,
    output logic       halted,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        F_ADDR  = 4'd1,
        F_READ  = 4'd2,
        F_IR    = 4'd3,
        DECODE  = 4'd4,
        EXEC    = 4'd5,
        M_ADDR  = 4'd6,
        M_READ  = 4'd7,
        M_WRITE = 4'd8,
        WB      = 4'd9,
        HALT    = 4'd10
    } state_t;

    // Strobe set decoded from the state being entered; mem_ready-gated bits are armed here.
    typedef struct packed {
        logic       load_mar;
        logic       mbr_arm;
        logic       load_ir;
        logic       inc_pc;
        logic       load_pc;
        logic       load_acc;
        logic       read_rom;
        logic       read_ram;
        logic       write_ram;
        logic [1:0] alu_sel;
        logic [1:0] mux_sel;
        logic       halted;
        logic       done;
        logic       done_wr;
    } strobes_t;

    state_t   state_r;
    state_t   state_next_s;
    strobes_t out_r;
    logic     ready_s;

`ifdef SEQ_WAIT_STATE_EN
    assign ready_s = mem_ready;
`else
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = mem_ready;
    assign ready_s = 1'b1;
`endif

    function automatic strobes_t decode(input state_t st, input logic [3:0] op);
        strobes_t s;
        s = '0;
        case (st)
            F_ADDR:  s.load_mar = 1'b1;
            F_READ: begin
                s.read_rom = 1'b1;
                s.mbr_arm  = 1'b1;
            end
            F_IR: begin
                s.load_ir = 1'b1;
                s.inc_pc  = 1'b1;
            end
            EXEC: begin
                s.done = 1'b1;
                case (op)
                    4'b0000, 4'b0011, 4'b0100, 4'b0101,
                    4'b0110, 4'b0111, 4'b1000: s.load_acc = 1'b1;
                    4'b1001: begin
                        s.load_acc = 1'b1;
                        s.alu_sel  = 2'b11;
                    end
                    4'b1101: s.load_pc = 1'b1;
                    default: s.load_acc = 1'b0;
                endcase
            end
            M_ADDR: begin
                s.load_mar = 1'b1;
                s.mux_sel  = 2'b01;
            end
            M_READ: begin
                s.read_ram = 1'b1;
                s.mbr_arm  = 1'b1;
            end
            M_WRITE: begin
                s.write_ram = 1'b1;
                s.done_wr   = 1'b1;
            end
            WB: begin
                s.load_acc = 1'b1;
                s.done     = 1'b1;
            end
            HALT:    s.halted = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    // Next-state selection.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE:    state_next_s = run ? F_ADDR : IDLE;
            F_ADDR:  state_next_s = F_READ;
            F_READ:  state_next_s = ready_s ? F_IR : F_READ;
            F_IR:    state_next_s = DECODE;
            DECODE: begin
                if (ir_opcode == 4'b0001 || ir_opcode == 4'b0010) begin
                    state_next_s = M_ADDR;
                end else if (ir_opcode == 4'b1111) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = EXEC;
                end
            end
            EXEC:    state_next_s = F_ADDR;
            M_ADDR: begin
                if (ir_opcode == 4'b0001) begin
                    state_next_s = M_WRITE;
                end else if (ir_opcode == 4'b0010) begin
                    state_next_s = M_READ;
                end else begin
                    state_next_s = F_ADDR;
                end
            end
            M_READ:  state_next_s = ready_s ? WB : M_READ;
            M_WRITE: state_next_s = ready_s ? F_ADDR : M_WRITE;
            WB:      state_next_s = F_ADDR;
            HALT:    state_next_s = HALT;
            default: state_next_s = IDLE;
        endcase
    end

    // State and strobe registers; strobes are decoded ahead so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            out_r   <= '0;
        end else begin
            state_r <= state_next_s;
            out_r   <= decode(state_next_s, ir_opcode);
        end
    end

    assign load_mar   = out_r.load_mar;
    assign load_mbr   = out_r.mbr_arm & ready_s;
    assign load_ir    = out_r.load_ir;
    assign inc_pc     = out_r.inc_pc;
    assign load_pc    = out_r.load_pc;
    assign load_acc   = out_r.load_acc;
    assign read_rom   = out_r.read_rom;
    assign read_ram   = out_r.read_ram;
    assign write_ram  = out_r.write_ram;
    assign alu_sel    = out_r.alu_sel;
    assign mux_sel_u9 = out_r.mux_sel;
    assign halted     = out_r.halted;
    assign instr_done = out_r.done | (out_r.done_wr & ready_s);
    assign state      = state_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed per-cycle expectations queued by stimulus, checked by a monitor.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] ir_opcode;
    logic       mem_ready;
    logic       load_mar, load_mbr, load_ir, inc_pc, load_pc, load_acc;
    logic       read_rom, read_ram, write_ram;
    logic [1:0] alu_sel, mux_sel_u9;
    logic       halted, instr_done;
    logic [3:0] state;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
        .load_mar(load_mar), .load_mbr(load_mbr), .load_ir(load_ir), .inc_pc(inc_pc),
        .load_pc(load_pc), .load_acc(load_acc), .read_rom(read_rom), .read_ram(read_ram),
        .write_ram(write_ram), .alu_sel(alu_sel), .mux_sel_u9(mux_sel_u9),
        .halted(halted), .instr_done(instr_done), .state(state)
    );

    localparam logic [3:0] IDLE = 4'd0, F_ADDR = 4'd1, F_READ = 4'd2, F_IR = 4'd3, DECODE = 4'd4,
                           EXEC = 4'd5, M_ADDR = 4'd6, M_READ = 4'd7, M_WRITE = 4'd8, WB = 4'd9,
                           HALT = 4'd10;

    // Bit layout of the observed strobe word.
    localparam logic [14:0] NONE = 15'h0000, MAR = 15'h4000, MBR = 15'h2000, IR = 15'h1000,
                            INC = 15'h0800, LPC = 15'h0400, ACC = 15'h0200, ROM = 15'h0100,
                            RAM = 15'h0080, WR = 15'h0040, ALU3 = 15'h0030, MUX1 = 15'h0004,
                            HLT = 15'h0002, DONE = 15'h0001;

    typedef struct {
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [18:0] obs;
            e = q.pop_front();
            obs = {state, load_mar, load_mbr, load_ir, inc_pc, load_pc, load_acc,
                   read_rom, read_ram, write_ram, alu_sel, mux_sel_u9, halted, instr_done};
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s: got state=%0d strobes=%h, want state=%0d strobes=%h",
                         e.name, obs[18:15], obs[14:0], e.v[18:15], e.v[14:0]);
            end
            total++;
            if ({1'b0, read_rom} + {1'b0, read_ram} + {1'b0, write_ram} > 2'd1) begin
                bad++;
                $display("FAIL %s_excl: got rom=%b ram=%b wr=%b, want at most one",
                         e.name, read_rom, read_ram, write_ram);
            end
        end
    end

    task automatic step(input logic r, input logic rn, input logic mr, input logic [3:0] op,
                        input logic [3:0] st, input logic [14:0] sb, input string nm);
        rst = r;
        run = rn;
        mem_ready = mr;
        ir_opcode = op;
        q.push_back('{name: nm, v: {st, sb}});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] op, input string nm);
        step(1'b0, 1'b0, 1'b1, op, F_ADDR, MAR, nm);
        step(1'b0, 1'b0, 1'b1, op, F_READ, ROM | MBR, nm);
        step(1'b0, 1'b0, 1'b1, op, F_IR, IR | INC, nm);
        step(1'b0, 1'b0, 1'b1, op, DECODE, NONE, nm);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;
        ir_opcode = 4'h0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 4'h3, IDLE, NONE, "reset");
        step(1'b0, 1'b0, 1'b0, 4'h3, IDLE, NONE, "reset");
        step(1'b0, 1'b0, 1'b0, 4'h3, IDLE, NONE, "idle_norun");
        step(1'b0, 1'b1, 1'b0, 4'h3, IDLE, NONE, "idle_run");

        fetch(4'h3, "alu");
        step(1'b0, 1'b0, 1'b1, 4'h3, EXEC, ACC | DONE, "alu_exec");
        fetch(4'h9, "alu9");
        step(1'b0, 1'b0, 1'b1, 4'h9, EXEC, ACC | ALU3 | DONE, "alu9_exec");
        fetch(4'hD, "jump");
        step(1'b0, 1'b0, 1'b1, 4'hD, EXEC, LPC | DONE, "jump_exec");
        fetch(4'hA, "nop");
        step(1'b0, 1'b0, 1'b1, 4'hA, EXEC, DONE, "nop_exec");

        fetch(4'h2, "load");
        step(1'b0, 1'b0, 1'b0, 4'h2, M_ADDR, MAR | MUX1, "load_maddr");
`ifdef SEQ_WAIT_STATE_EN
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'h2, M_READ, RAM, "load_wait");
        step(1'b0, 1'b0, 1'b1, 4'h2, M_READ, RAM | MBR, "load_read");
`else
        step(1'b0, 1'b0, 1'b0, 4'h2, M_READ, RAM | MBR, "load_read");
`endif
        step(1'b0, 1'b0, 1'b0, 4'h2, WB, ACC | DONE, "load_wb");

        fetch(4'h1, "store");
        step(1'b0, 1'b0, 1'b0, 4'h1, M_ADDR, MAR | MUX1, "store_maddr");
`ifdef SEQ_WAIT_STATE_EN
        step(1'b0, 1'b0, 1'b0, 4'h1, M_WRITE, WR, "store_wait");
        step(1'b0, 1'b0, 1'b1, 4'h1, M_WRITE, WR | DONE, "store_write");
`else
        step(1'b0, 1'b0, 1'b0, 4'h1, M_WRITE, WR | DONE, "store_write");
`endif

        // Reset taken while the fetch read is outstanding.
        step(1'b0, 1'b0, 1'b0, 4'h0, F_ADDR, MAR, "rst_faddr");
`ifdef SEQ_WAIT_STATE_EN
        step(1'b0, 1'b0, 1'b0, 4'h0, F_READ, ROM, "rst_wait");
        step(1'b1, 1'b0, 1'b0, 4'h0, F_READ, ROM, "rst_wait");
`else
        step(1'b1, 1'b0, 1'b0, 4'h0, F_READ, ROM | MBR, "rst_fread");
`endif
        step(1'b0, 1'b0, 1'b1, 4'h0, IDLE, NONE, "rst_idle");
        step(1'b0, 1'b0, 1'b1, 4'h0, IDLE, NONE, "rst_idle");

        step(1'b0, 1'b1, 1'b0, 4'hF, IDLE, NONE, "halt_run");
        fetch(4'hF, "halt");
        for (int i = 0; i < 20; i++) step(1'b0, i[0], 1'b1, 4'hF, HALT, HLT, "halt_hold");
        step(1'b1, 1'b1, 1'b0, 4'hF, HALT, HLT, "halt_hold");
        step(1'b0, 1'b0, 1'b0, 4'hF, IDLE, NONE, "halt_rst");
        step(1'b0, 1'b0, 1'b0, 4'hF, IDLE, NONE, "halt_rst");

        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
